// File: rtl/branch_unit_pht.sv
// Branch resolution with a PHT of 2-bit saturating counters for fetch prediction.
// It also produces a registered mispredict flag and saturating performance counters.
package branch_unit_pht_pkg;
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branch_op_t;

    typedef enum logic {
        PC_NEXT   = 1'b0,
        PC_BRANCH = 1'b1
    } pc_branch_mux_t;
endpackage

module branch_unit_pht
    import branch_unit_pht_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PHT_ENTRIES = 16,
    parameter int IDX_LSB     = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             fetch_pred_taken,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  branch_op_t       op,
    input  logic             branch_always,
    input  logic             branch_instr,
    input  logic             ex_pred_taken,
    output pc_branch_mux_t   take,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int IDX_W = $clog2(PHT_ENTRIES);

    logic [1:0]       pht_q [PHT_ENTRIES];
    logic [1:0]       pht_d [PHT_ENTRIES];
    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0] fetch_idx, ex_idx;
    logic             cond, take_bit, upd;

    assign fetch_idx = fetch_pc[IDX_LSB +: IDX_W];
    assign ex_idx    = ex_pc[IDX_LSB +: IDX_W];

    // Only the index slice of the PCs matters; the rest is intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc, ex_pc};

    always_comb begin
        cond = 1'b0;
        case (op)
            BEQ:     cond = (a == b);
            BNE:     cond = (a != b);
            BLT:     cond = ($signed(a) <  $signed(b));
            BGE:     cond = ($signed(a) >= $signed(b));
            BLTU:    cond = (a <  b);
            BGEU:    cond = (a >= b);
            default: cond = 1'b0;
        endcase
    end

    assign take_bit         = branch_always | (branch_instr & cond);
    assign take             = take_bit ? PC_BRANCH : PC_NEXT;
    assign fetch_pred_taken = pht_q[fetch_idx][1];
    assign upd              = ex_valid & branch_instr & ~branch_always;

    // Fetch reads pht_q directly, so a same-index update is invisible until next cycle.
    always_comb begin
        pht_d = pht_q;
        if (upd) begin
            if (cond) begin
                if (pht_q[ex_idx] != 2'b11) pht_d[ex_idx] = pht_q[ex_idx] + 2'b01;
            end else begin
                if (pht_q[ex_idx] != 2'b00) pht_d[ex_idx] = pht_q[ex_idx] - 2'b01;
            end
        end
    end

    always_comb begin
        mispredict_d       = ex_valid & (branch_instr | branch_always) & (take_bit != ex_pred_taken);
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (upd && branch_count_q != '1)
            branch_count_d = branch_count_q + 1'b1;
        if (mispredict_d && mispredict_count_q != '1)
            mispredict_count_d = mispredict_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
            mispredict_q       <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= pht_d[i];
            mispredict_q       <= mispredict_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign mispredict       = mispredict_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_unit_pht.sv
// Directed bench for branch_unit_pht: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_unit_pht;
    import branch_unit_pht_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   fetch_pc = '0;
    logic          fetch_pred_taken;
    logic          ex_valid = 1'b0;
    logic [31:0]   ex_pc = '0;
    logic [31:0]   a = '0;
    logic [31:0]   b = '0;
    branch_op_t    op = BEQ;
    logic          branch_always = 1'b0;
    logic          branch_instr = 1'b0;
    logic          ex_pred_taken = 1'b0;
    pc_branch_mux_t take;
    logic          mispredict;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    branch_unit_pht #(.XLEN(32), .PHT_ENTRIES(16), .IDX_LSB(2), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .a(a), .b(b), .op(op),
        .branch_always(branch_always), .branch_instr(branch_instr),
        .ex_pred_taken(ex_pred_taken), .take(take), .mispredict(mispredict),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          take;
        logic          pred;
        logic          mis;
        logic [CW-1:0] bc;
        logic [CW-1:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "take", 32'(take == PC_BRANCH), 32'(e.take));
            chk(e.name, "pred", 32'(fetch_pred_taken), 32'(e.pred));
            chk(e.name, "mispredict", 32'(mispredict), 32'(e.mis));
            chk(e.name, "branch_count", 32'(branch_count), 32'(e.bc));
            chk(e.name, "mispredict_count", 32'(mispredict_count), 32'(e.mc));
        end
    end

    // Drives one cycle of inputs; expectations describe what is visible during that cycle.
    task automatic step(input string nm, input logic r, input logic [31:0] fpc,
                        input logic v, input logic [31:0] epc, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [2:0] o, input logic ba,
                        input logic bi, input logic ept, input logic et, input logic ep,
                        input logic em, input int ebc, input int emc);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; fetch_pc = fpc; ex_valid = v; ex_pc = epc; a = aa; b = bb;
        op = branch_op_t'(o); branch_always = ba; branch_instr = bi; ex_pred_taken = ept;
        e.name = nm; e.take = et; e.pred = ep; e.mis = em;
        e.bc = CW'(ebc); e.mc = CW'(emc);
        exp_q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic [31:0] fpc, input logic ep,
                        input logic em, input int ebc, input int emc);
        step(nm, 1'b0, fpc, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0,
             1'b0, ep, em, ebc, emc);
    endtask

    task automatic comb_take(input string nm, input logic [2:0] o, input logic [31:0] aa,
                             input logic [31:0] bb, input logic et);
        step(nm, 1'b0, 32'h30, 1'b0, 32'h30, aa, bb, o, 1'b0, 1'b1, 1'b0, et, 1'b0, 1'b0, 6, 3);
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 16; i++) idle("sweep", 32'(i * 4), 1'b0, 1'b0, 0, 0);

        // Signed BLT taken, predicted not-taken: PHT[4] 01->10
        step("blt", 1'b0, 32'h10, 1'b1, 32'h10, 32'hFFFF_FFFF, 32'h1, 3'b100, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 0, 0);
        idle("blt_after", 32'h10, 1'b1, 1'b1, 1, 1);

        // Unsigned BLTU not-taken 4x: PHT[4] 10->01->00->00->00
        step("bltu0", 1'b0, 32'h10, 1'b1, 32'h10, 32'hFFFF_FFFF, 32'h1, 3'b110, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b1, 1'b0, 1, 1);
        step("bltu1", 1'b0, 32'h10, 1'b1, 32'h10, 32'hFFFF_FFFF, 32'h1, 3'b110, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 2, 1);
        step("bltu2", 1'b0, 32'h10, 1'b1, 32'h10, 32'hFFFF_FFFF, 32'h1, 3'b110, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 3, 1);
        step("bltu3", 1'b0, 32'h10, 1'b1, 32'h10, 32'hFFFF_FFFF, 32'h1, 3'b110, 1'b0, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b0, 4, 1);
        idle("bltu_after", 32'h10, 1'b0, 1'b0, 5, 1);

        // Same-index fetch/execute: fetch sees the old counter
        step("collide", 1'b0, 32'h20, 1'b1, 32'h20, 32'd5, 32'd5, 3'b000, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 5, 1);
        idle("collide_after", 32'h20, 1'b1, 1'b1, 6, 2);

        // Jump predicted not-taken: mispredicts, no PHT update, no branch count
        step("jump", 1'b0, 32'h20, 1'b1, 32'h30, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0,
             1'b1, 1'b1, 1'b0, 6, 2);
        idle("jump_after", 32'h30, 1'b0, 1'b1, 6, 3);
        // Both flags set: treated as a jump; correctly predicted taken
        step("both", 1'b0, 32'h30, 1'b1, 32'h30, 32'd1, 32'd2, 3'b000, 1'b1, 1'b1, 1'b1,
             1'b1, 1'b0, 1'b0, 6, 3);
        idle("both_after", 32'h30, 1'b0, 1'b0, 6, 3);

        comb_take("bne_eq", 3'b001, 32'd5, 32'd5, 1'b0);
        comb_take("bne_ne", 3'b001, 32'd5, 32'd6, 1'b1);
        comb_take("bge_neg", 3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0);
        comb_take("bge_eq", 3'b101, 32'd1, 32'd1, 1'b1);
        comb_take("bgeu_big", 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b1);
        comb_take("bgeu_lt", 3'b111, 32'd1, 32'd2, 1'b0);
        comb_take("blt_eq", 3'b100, 32'd1, 32'd1, 1'b0);
        comb_take("bltu_big", 3'b110, 32'd1, 32'hFFFF_FFFF, 1'b1);
        comb_take("op010", 3'b010, 32'd0, 32'd1, 1'b0);
        comb_take("op011", 3'b011, 32'd0, 32'd0, 1'b0);

        // Reset coinciding with a taken update discards it
        step("rst_upd", 1'b1, 32'h34, 1'b1, 32'h34, 32'd5, 32'd5, 3'b000, 1'b0, 1'b1, 1'b0,
             1'b1, 1'b0, 1'b0, 6, 3);
        idle("rst_after34", 32'h34, 1'b0, 1'b0, 0, 0);
        idle("rst_after20", 32'h20, 1'b0, 1'b0, 0, 0);

        // 16 mispredicted jumps: mispredict_count saturates at 15
        for (int k = 0; k < 16; k++)
            step("mc_sat", 1'b0, 32'h20, 1'b1, 32'h20, 32'h0, 32'h0, 3'b000, 1'b1, 1'b0, 1'b0,
                 1'b1, 1'b0, (k > 0), 0, (k > 15) ? 15 : k);
        idle("mc_sat_a", 32'h20, 1'b0, 1'b1, 0, 15);
        idle("mc_sat_b", 32'h20, 1'b0, 1'b0, 0, 15);

        // 16 correctly predicted taken BEQ on idx 0: branch_count and PHT saturate high
        for (int k = 0; k < 16; k++)
            step("bc_sat", 1'b0, 32'h0, 1'b1, 32'h0, 32'd7, 32'd7, 3'b000, 1'b0, 1'b1, 1'b1,
                 1'b1, (k > 0), 1'b0, k, 15);
        idle("bc_sat_after", 32'h0, 1'b1, 1'b0, 15, 15);

        begin
            int guard = 0;
            while (exp_q.size() != 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain queue left %0d expected 0", exp_q.size());
            end
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
